// File: rtl/conv_layer_sched_pkg.sv
// rtl/conv_layer_sched_pkg.sv - shared types, sizing helpers and defaults for the layer scheduler
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ADVANCE,
        DONE
    } state_t;

    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;
    localparam int DEF_CH_OUT     = 8;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_TIMEOUT    = 1024;

    // Valid-convolution output size for a 3x3 kernel
    function automatic int out_dim(input int img);
        return img - 2;
    endfunction

    function automatic int total_pos(input int w, input int h, input int c);
        return w * h * c;
    endfunction

    // Counter width that never collapses to zero bits for a size-1 dimension
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ROW_W = cnt_width(out_dim(DEF_IMG_H));
    localparam int DEF_COL_W = cnt_width(out_dim(DEF_IMG_W));
    localparam int DEF_CH_W  = cnt_width(DEF_CH_OUT);

endpackage

// File: rtl/conv_layer_sched_if.sv
// rtl/conv_layer_sched_if.sv - sequencer and conv-engine control bundle of the layer scheduler
interface conv_layer_sched_if
    import conv_sched_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int CH_OUT     = DEF_CH_OUT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int ROW_W = cnt_width(out_dim(IMG_H));
    localparam int COL_W = cnt_width(out_dim(IMG_W));
    localparam int CH_W  = cnt_width(CH_OUT);

    logic                  layer_start;
    logic                  layer_abort;
    logic                  conv_start;
    logic                  conv_done;
    logic                  weight_reload;
    logic [ROW_W-1:0]      win_row;
    logic [COL_W-1:0]      win_col;
    logic [CH_W-1:0]       out_ch;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  busy;
    logic                  layer_done;
    logic                  err_timeout;

    modport master (
        input  layer_start, layer_abort, conv_done,
        output conv_start, weight_reload, win_row, win_col, out_ch, out_addr,
               busy, layer_done, err_timeout
    );

    modport slave (
        output layer_start, layer_abort, conv_done,
        input  conv_start, weight_reload, win_row, win_col, out_ch, out_addr,
               busy, layer_done, err_timeout
    );
endinterface

// File: rtl/conv_layer_sched_pos_counter.sv
// rtl/conv_layer_sched_pos_counter.sv - nested col/row/channel position counter with linear address
module conv_pos_counter
    import conv_sched_pkg::*;
#(
    parameter int OUT_W      = 26,
    parameter int OUT_H      = 26,
    parameter int CH_OUT     = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int COL_W      = cnt_width(OUT_W),
    parameter int ROW_W      = cnt_width(OUT_H),
    parameter int CH_W       = cnt_width(CH_OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic [CH_W-1:0]       ch,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  chan_end,
    output logic                  last
);
    logic col_end;
    logic row_end;
    logic ch_end;

    assign col_end  = (col == COL_W'(OUT_W - 1));
    assign row_end  = (row == ROW_W'(OUT_H - 1));
    assign ch_end   = (ch == CH_W'(CH_OUT - 1));
    assign chan_end = col_end && row_end;
    assign last     = chan_end && ch_end;

    // Step col, carry into row then channel; address simply follows the scan order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row <= '0;
                    ch  <= ch_end ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - walks all output positions/channels, one conv engine start per window
module conv_layer_sched
    import conv_sched_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int CH_OUT     = DEF_CH_OUT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    conv_layer_sched_if.master bus
);
    localparam int OUT_W = out_dim(IMG_W);
    localparam int OUT_H = out_dim(IMG_H);
    localparam int COL_W = cnt_width(OUT_W);
    localparam int ROW_W = cnt_width(OUT_H);
    localparam int CH_W  = cnt_width(CH_OUT);
    localparam int TO_W  = cnt_width(TIMEOUT);

    if (IMG_W < 3 || IMG_H < 3) begin : g_bad_size
        $error("conv_layer_sched: IMG_W and IMG_H must be at least 3");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("conv_layer_sched: TIMEOUT must be at least 2");
    end
    if (ADDR_WIDTH < 31 && total_pos(OUT_W, OUT_H, CH_OUT) > (1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("conv_layer_sched: ADDR_WIDTH too small for the layer");
    end

    state_t            state;
    logic [TO_W-1:0]   wait_cnt;
    logic              conv_start;
    logic              weight_reload;
    logic              busy;
    logic              layer_done;
    logic              err_timeout;
    logic              cnt_clear;
    logic              cnt_inc;
    logic              chan_end;
    logic              last;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [CH_W-1:0]   ch;
    logic [ADDR_WIDTH-1:0] addr;

    // Abort suppresses the advance so the counters keep the aborted position
    assign cnt_clear = (state == IDLE) && bus.layer_start;
    assign cnt_inc   = (state == ADVANCE) && !bus.layer_abort;

    conv_pos_counter #(
        .OUT_W      (OUT_W),
        .OUT_H      (OUT_H),
        .CH_OUT     (CH_OUT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W),
        .CH_W       (CH_W)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .col      (col),
        .row      (row),
        .ch       (ch),
        .addr     (addr),
        .chan_end (chan_end),
        .last     (last)
    );

    // Layer FSM; pulses are registered so they line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            conv_start    <= 1'b0;
            weight_reload <= 1'b0;
            busy          <= 1'b0;
            layer_done    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            conv_start    <= 1'b0;
            weight_reload <= 1'b0;
            layer_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.layer_start) begin
                        err_timeout   <= 1'b0;
                        busy          <= 1'b1;
                        conv_start    <= 1'b1;
                        weight_reload <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    if (bus.layer_abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.layer_abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (bus.conv_done) begin
                        state <= ADVANCE;
                    end else if (wait_cnt == TO_W'(TIMEOUT - 2)) begin
                        // Counting starts at ISSUE, so this lands TIMEOUT cycles after conv_start
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ADVANCE: begin
                    if (bus.layer_abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (last) begin
                        layer_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        conv_start    <= 1'b1;
                        weight_reload <= chan_end;
                        state         <= ISSUE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.conv_start    = conv_start;
    assign bus.weight_reload = weight_reload;
    assign bus.win_row       = row;
    assign bus.win_col       = col;
    assign bus.out_ch        = ch;
    assign bus.out_addr      = addr;
    assign bus.busy          = busy;
    assign bus.layer_done    = layer_done;
    assign bus.err_timeout   = err_timeout;
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb/tb_conv_layer_sched.sv - directed/randomized self-checking bench for conv_layer_sched
module tb_conv_layer_sched;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   a_starts = 0;
    int   a_dones = 0;
    int   b_starts = 0;
    int   b_dones = 0;
    int   prev_cyc;
    int   prev_lat;
    bit   have_prev;

    always #5 clk = ~clk;

    conv_layer_sched_if #(.IMG_W(5), .IMG_H(5), .CH_OUT(2), .ADDR_WIDTH(16)) a_if ();
    conv_layer_sched_if #(.IMG_W(3), .IMG_H(4), .CH_OUT(1), .ADDR_WIDTH(16)) b_if ();

    conv_layer_sched #(.IMG_W(5), .IMG_H(5), .CH_OUT(2), .ADDR_WIDTH(16), .TIMEOUT(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    conv_layer_sched #(.IMG_W(3), .IMG_H(4), .CH_OUT(1), .ADDR_WIDTH(16), .TIMEOUT(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_if.conv_start === 1'b1) a_starts <= a_starts + 1;
        if (a_if.layer_done === 1'b1) a_dones <= a_dones + 1;
        if (b_if.conv_start === 1'b1) b_starts <= b_starts + 1;
        if (b_if.layer_done === 1'b1) b_dones <= b_dones + 1;
    end

    // Reference model: position p in scan order (col fastest, then row, then channel)
    function automatic int m_col(input int p, input int w);
        return p % w;
    endfunction
    function automatic int m_row(input int p, input int w, input int h);
        return (p % (w * h)) / w;
    endfunction
    function automatic int m_ch(input int p, input int w, input int h);
        return p / (w * h);
    endfunction
    function automatic int m_reload(input int p, input int w, input int h);
        return ((p % (w * h)) == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_zero(input string tag);
        check({tag, "_conv_start"}, 32'(a_if.conv_start), 0);
        check({tag, "_reload"}, 32'(a_if.weight_reload), 0);
        check({tag, "_row"}, 32'(a_if.win_row), 0);
        check({tag, "_col"}, 32'(a_if.win_col), 0);
        check({tag, "_ch"}, 32'(a_if.out_ch), 0);
        check({tag, "_addr"}, 32'(a_if.out_addr), 0);
        check({tag, "_busy"}, 32'(a_if.busy), 0);
        check({tag, "_layer_done"}, 32'(a_if.layer_done), 0);
        check({tag, "_err"}, 32'(a_if.err_timeout), 0);
    endtask

    task automatic a_launch();
        a_if.layer_start = 1'b1;
        @(negedge clk);
        a_if.layer_start = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic a_wait_start(input string tag, output bit ok);
        int n;
        n = 0;
        while (a_if.conv_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (a_if.conv_start === 1'b1);
        check({tag, "_start_seen"}, 32'(ok), 1);
    endtask

    // Expect the start of position p, check it, then answer after lat cycles
    task automatic a_pos(input int p, input int lat, input bit stray, input bit abort_here);
        bit ok;
        a_wait_start("a_pos", ok);
        if (!ok) return;
        check($sformatf("a_col_p%0d", p), 32'(a_if.win_col), m_col(p, 3));
        check($sformatf("a_row_p%0d", p), 32'(a_if.win_row), m_row(p, 3, 3));
        check($sformatf("a_ch_p%0d", p), 32'(a_if.out_ch), m_ch(p, 3, 3));
        check($sformatf("a_addr_p%0d", p), 32'(a_if.out_addr), p);
        check($sformatf("a_reload_p%0d", p), 32'(a_if.weight_reload), m_reload(p, 3, 3));
        if (have_prev) check($sformatf("a_spacing_p%0d", p), cyc - prev_cyc, prev_lat + 2);
        prev_cyc  = cyc;
        prev_lat  = lat;
        have_prev = 1'b1;
        if (stray) begin
            a_if.conv_done   = 1'b1;
            a_if.layer_start = 1'b1;
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            a_if.conv_done   = 1'b0;
            a_if.layer_start = 1'b0;
        end
        a_if.conv_done = 1'b1;
        if (abort_here) a_if.layer_abort = 1'b1;
        @(negedge clk);
        a_if.conv_done   = 1'b0;
        a_if.layer_abort = 1'b0;
    endtask

    initial begin
        int  lat;
        int  s0;
        int  d0;
        int  c0;
        int  n;
        bit  ok;

        rst = 1'b1;
        a_if.layer_start = 1'b0;
        a_if.layer_abort = 1'b0;
        a_if.conv_done   = 1'b0;
        b_if.layer_start = 1'b0;
        b_if.layer_abort = 1'b0;
        b_if.conv_done   = 1'b0;
        have_prev = 1'b0;
        prev_cyc  = 0;
        prev_lat  = 0;
        repeat (2) @(negedge clk);
        a_zero("reset");
        check("b_reset_busy", 32'(b_if.busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full 5x5, 2-channel layer with random engine latency
        s0 = a_starts;
        d0 = a_dones;
        a_launch();
        check("a_busy_after_start", 32'(a_if.busy), 1);
        for (int p = 0; p < 18; p++) begin
            lat = $urandom_range(1, 5);
            if (p == 2 && lat < 2) lat = 2;
            a_pos(p, lat, p == 2, 1'b0);
        end
        check("full_done_early", 32'(a_if.layer_done), 0);
        check("full_busy_adv", 32'(a_if.busy), 1);
        @(negedge clk);
        check("full_layer_done", 32'(a_if.layer_done), 1);
        check("full_busy_done", 32'(a_if.busy), 1);
        @(negedge clk);
        check("full_done_once", 32'(a_if.layer_done), 0);
        check("full_busy_end", 32'(a_if.busy), 0);
        check("full_start_count", a_starts - s0, 18);
        check("full_done_count", a_dones - d0, 1);

        // Engine never answers: timeout
        d0 = a_dones;
        a_launch();
        a_wait_start("to", ok);
        c0 = cyc;
        n = 0;
        while (a_if.err_timeout !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_err", 32'(a_if.err_timeout), 1);
        check("to_latency", cyc - c0, 16);
        check("to_busy", 32'(a_if.busy), 0);
        check("to_no_layer_done", a_dones - d0, 0);
        s0 = a_starts;
        repeat (5) @(negedge clk);
        check("to_no_start", a_starts - s0, 0);
        check("to_sticky", 32'(a_if.err_timeout), 1);

        // New start clears the flag; then abort together with done at position 7
        a_launch();
        check("to_cleared", 32'(a_if.err_timeout), 0);
        d0 = a_dones;
        for (int p = 0; p < 7; p++) begin
            a_pos(p, $urandom_range(1, 4), 1'b0, p == 6);
        end
        check("abort_busy", 32'(a_if.busy), 0);
        check("abort_addr", 32'(a_if.out_addr), 6);
        check("abort_row", 32'(a_if.win_row), m_row(6, 3, 3));
        check("abort_col", 32'(a_if.win_col), m_col(6, 3));
        s0 = a_starts;
        repeat (8) @(negedge clk);
        check("abort_no_start", a_starts - s0, 0);
        check("abort_no_done", a_dones - d0, 0);
        check("abort_addr_hold", 32'(a_if.out_addr), 6);
        check("abort_err_hold", 32'(a_if.err_timeout), 0);

        // Start and abort together in IDLE: start wins; then async reset mid-WAIT
        a_if.layer_abort = 1'b1;
        a_launch();
        a_if.layer_abort = 1'b0;
        for (int p = 0; p < 4; p++) begin
            a_pos(p, $urandom_range(1, 4), 1'b0, 1'b0);
        end
        a_wait_start("rst", ok);
        check("rst_pre_addr", 32'(a_if.out_addr), 4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 a_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        s0 = a_starts;
        repeat (8) @(negedge clk);
        check("rst_no_start", a_starts - s0, 0);
        check("rst_idle", 32'(a_if.busy), 0);
        a_launch();
        a_pos(0, $urandom_range(1, 4), 1'b0, 1'b0);
        a_if.layer_abort = 1'b1;
        @(negedge clk);
        a_if.layer_abort = 1'b0;

        // Degenerate 1x2 output map, single channel
        s0 = b_starts;
        d0 = b_dones;
        b_if.layer_start = 1'b1;
        @(negedge clk);
        b_if.layer_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            n = 0;
            while (b_if.conv_start !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("b_start_p%0d", p), 32'(b_if.conv_start), 1);
            check($sformatf("b_row_p%0d", p), 32'(b_if.win_row), m_row(p, 1, 2));
            check($sformatf("b_col_p%0d", p), 32'(b_if.win_col), m_col(p, 1));
            check($sformatf("b_ch_p%0d", p), 32'(b_if.out_ch), m_ch(p, 1, 2));
            check($sformatf("b_addr_p%0d", p), 32'(b_if.out_addr), p);
            check($sformatf("b_reload_p%0d", p), 32'(b_if.weight_reload), m_reload(p, 1, 2));
            lat = $urandom_range(1, 4);
            repeat (lat) @(negedge clk);
            b_if.conv_done = 1'b1;
            @(negedge clk);
            b_if.conv_done = 1'b0;
        end
        n = 0;
        while (b_if.layer_done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b_layer_done", 32'(b_if.layer_done), 1);
        @(negedge clk);
        check("b_start_count", b_starts - s0, 2);
        check("b_done_count", b_dones - d0, 1);
        check("b_busy_end", 32'(b_if.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
